// File: rtl/spi_tx.sv
// SPI master transmitter: one 8- or 16-bit frame per accepted start, MSB first,
// SCLK idling high, with the receiver's sampling edge chosen per frame.
module spi_tx #(
  parameter int unsigned SCLK_DIV = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] tx_data,
  input  logic        len8,
  input  logic        edg,
  output logic        SS_n,
  output logic        SCLK,
  output logic        MOSI,
  output logic        busy,
  output logic        done
);
  localparam int unsigned H  = SCLK_DIV / 2;
  localparam int unsigned CW = (H > 1) ? $clog2(H) : 1;
  localparam int unsigned EW = 5;

  typedef enum logic [2:0] {IDLE, FRONT, SHIFT, BACK, GAP} state_t;

  state_t        state_q;
  logic [CW-1:0] cnt_q;
  logic [EW-1:0] edge_q;
  logic [14:0]   shreg_q;
  logic          len8_q;
  logic          edg_q;
  logic          ss_n_q;
  logic          sclk_q;
  logic          mosi_q;
  logic          busy_q;
  logic          done_q;

  logic phase_end_c;
  logic last_edge_c;
  logic advance_c;

  // edge_q holds the index of the SCLK edge about to be produced
  assign phase_end_c = (cnt_q == CW'(H - 1));
  assign last_edge_c = (edge_q == (len8_q ? EW'(15) : EW'(31)));
  assign advance_c   = (edge_q[0] != edg_q) && (edge_q != '0) && !last_edge_c;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      edge_q  <= '0;
      shreg_q <= '0;
      len8_q  <= 1'b0;
      edg_q   <= 1'b0;
      ss_n_q  <= 1'b1;
      sclk_q  <= 1'b1;
      mosi_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (state_q != IDLE) begin
        cnt_q <= phase_end_c ? '0 : cnt_q + CW'(1);
      end
      unique case (state_q)
        IDLE: begin
          if (start) begin
            state_q <= FRONT;
            cnt_q   <= '0;
            edge_q  <= '0;
            len8_q  <= len8;
            edg_q   <= edg;
            shreg_q <= len8 ? {tx_data[6:0], 8'h00} : tx_data[14:0];
            mosi_q  <= len8 ? tx_data[7] : tx_data[15];
            ss_n_q  <= 1'b0;
            busy_q  <= 1'b1;
          end
        end
        FRONT: begin
          if (phase_end_c) begin
            state_q <= SHIFT;
            sclk_q  <= 1'b0;
            edge_q  <= EW'(1);
          end
        end
        SHIFT: begin
          if (phase_end_c) begin
            sclk_q <= ~sclk_q;
            if (advance_c) begin
              mosi_q  <= shreg_q[14];
              shreg_q <= {shreg_q[13:0], 1'b0};
            end
            if (last_edge_c) begin
              state_q <= BACK;
              edge_q  <= '0;
            end else begin
              edge_q <= edge_q + EW'(1);
            end
          end
        end
        BACK: begin
          if (phase_end_c) begin
            state_q <= GAP;
            ss_n_q  <= 1'b1;
            mosi_q  <= 1'b0;
          end
        end
        GAP: begin
          // done and busy release land together in the last GAP cycle
          if (cnt_q == CW'(H - 2)) begin
            done_q <= 1'b1;
            busy_q <= 1'b0;
          end
          if (phase_end_c) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign SS_n = ss_n_q;
  assign SCLK = sclk_q;
  assign MOSI = mosi_q;
  assign busy = busy_q;
  assign done = done_q;
endmodule

// File: tb/tb_spi_tx.sv
// Scoreboard bench for spi_tx: frames are queued at issue time and a bus monitor
// decodes SS_n/SCLK/MOSI and checks each completed frame against the queue.
`timescale 1ns/1ps
module tb_spi_tx;
  localparam int unsigned H = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, len8, edg;
  logic [15:0] tx_data;
  logic        SS_n, SCLK, MOSI, busy, done;
  logic        start2, len8_2, edg2;
  logic [15:0] tx_data2;
  logic        ss2, sclk2, mosi2, busy2, done2;

  always #5 clk = ~clk;

  spi_tx #(.SCLK_DIV(4)) dut (
    .clk(clk), .rst(rst), .start(start), .tx_data(tx_data), .len8(len8), .edg(edg),
    .SS_n(SS_n), .SCLK(SCLK), .MOSI(MOSI), .busy(busy), .done(done)
  );

  spi_tx dut2 (
    .clk(clk), .rst(rst), .start(start2), .tx_data(tx_data2), .len8(len8_2), .edg(edg2),
    .SS_n(ss2), .SCLK(sclk2), .MOSI(mosi2), .busy(busy2), .done(done2)
  );

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [15:0] data;
    int          n;
    logic        edg;
    logic        trig;
  } exp_t;
  exp_t q[$];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic fail(input string nm);
    n_tests++;
    n_fail++;
    $display("FAIL %s: wait bound expired", nm);
  endtask

  // ---------------- monitor for the SCLK_DIV=4 instance ----------------
  logic        p_ss = 1'b1, p_sclk = 1'b1, p_mosi = 1'b0;
  bit          in_frame = 0, have_exp = 0, gap_act = 0;
  exp_t        cur;
  int          low_cnt, edges, nsamp, viol, gap_cnt, idle_bad0 = 0;
  logic [15:0] cap;

  always @(negedge clk) begin
    if (rst) begin
      if (in_frame && have_exp) void'(q.pop_front());
      in_frame = 0;
      gap_act  = 0;
    end else begin
      if (gap_act) begin
        gap_cnt++;
        if (gap_cnt > int'(H) - 1) begin
          fail("done_missing");
          gap_act = 0;
        end
      end
      if (done) begin
        if (!gap_act) check("done_unexpected", 32'(done), 32'(0));
        else begin
          check("done_pos", 32'(gap_cnt), 32'(H - 1));
          check("done_busy", 32'(busy), 32'(0));
          gap_act = 0;
        end
      end
      if (p_ss && !SS_n) begin
        in_frame = 1; low_cnt = 1; edges = 0; nsamp = 0; viol = 0; cap = '0;
        if (q.size() == 0) begin
          check("unexpected_frame", 32'(q.size()), 32'(1));
          have_exp = 0;
          cur = '{16'h0000, 16, 1'b0, 1'b0};
        end else begin
          have_exp = 1;
          cur = q[0];
        end
      end else if (in_frame && !SS_n) begin
        low_cnt++;
        if (!busy) viol++;
        if (SCLK != p_sclk) begin
          edges++;
          if (SCLK == cur.edg) begin
            cap = {cap[14:0], MOSI};
            nsamp++;
            if (MOSI != p_mosi) viol++;
          end else if (edges == 1 && MOSI != p_mosi) viol++;
        end else if (MOSI != p_mosi) viol++;
      end else if (in_frame && SS_n) begin
        in_frame = 0;
        if (have_exp) begin
          void'(q.pop_front());
          check("ss_low_len", 32'(low_cnt), 32'(int'(H) * (2 * cur.n + 1)));
          check("sclk_edges", 32'(edges), 32'(2 * cur.n));
          check("samples", 32'(nsamp), 32'(cur.n));
          check("data", 32'(cur.n == 8 ? {8'h00, cap[7:0]} : cap), 32'(cur.data));
          check("mosi_stable_busy", 32'(viol), 32'(0));
          check("rx_trigger", 32'(cur.n == 8 && cap[7:0] == 8'hA5), 32'(cur.trig));
        end
        gap_act = 1;
        gap_cnt = 0;
      end
      if (!in_frame && SS_n && (MOSI !== 1'b0 || SCLK !== 1'b1)) idle_bad0++;
    end
    p_ss = SS_n; p_sclk = SCLK; p_mosi = MOSI;
  end

  // ---------------- monitor for the default-divider instance ----------------
  logic p_ss2 = 1'b1, p_sclk2 = 1'b1;
  bit   seen2 = 0;
  int   run2 = 0, hi2 = 0, bad2 = 0, low2 = 0, frames2 = 0, idle_bad2 = 0;

  always @(negedge clk) begin
    if (rst) begin
      hi2 = 0;
      seen2 = 0;
    end else if (!ss2) begin
      if (p_ss2) begin
        if (seen2) check("ss_gap_ge16", 32'(hi2 >= 16), 32'(1));
        run2 = 1; low2 = 1; bad2 = 0;
      end else begin
        low2++;
        if (sclk2 != p_sclk2) begin
          if (run2 != 16) bad2++;
          run2 = 1;
        end else run2++;
      end
    end else begin
      if (!p_ss2) begin
        if (run2 != 16) bad2++;
        check("sclk_phase16", 32'(bad2), 32'(0));
        check("ss_low_div32", 32'(low2), 32'(16 * 33));
        frames2++;
        seen2 = 1;
        hi2 = 0;
      end
      hi2++;
      if (mosi2 !== 1'b0 || sclk2 !== 1'b1) idle_bad2++;
    end
    p_ss2 = ss2; p_sclk2 = sclk2;
  end

  // ---------------- stimulus ----------------
  task automatic wait_idle0();
    int k = 0;
    @(negedge clk);
    while ((busy || done || !SS_n) && k < 3000) begin
      @(negedge clk);
      k++;
    end
    if (k >= 3000) fail("idle_timeout");
  endtask

  task automatic wait_ss_high0();
    int k = 0;
    @(negedge clk);
    while (!SS_n && k < 3000) begin
      @(negedge clk);
      k++;
    end
    if (k >= 3000) fail("ss_high_timeout");
  endtask

  task automatic wait_done0();
    int k = 0;
    @(negedge clk);
    while (!done && k < 3000) begin
      @(negedge clk);
      k++;
    end
    if (k >= 3000) fail("done_timeout");
  endtask

  task automatic wait_done2();
    int k = 0;
    @(negedge clk);
    while (!done2 && k < 3000) begin
      @(negedge clk);
      k++;
    end
    if (k >= 3000) fail("done2_timeout");
  endtask

  task automatic send(input logic [15:0] d, input logic l8, input logic e,
                      input logic [15:0] expd, input logic trig);
    wait_idle0();
    tx_data = d; len8 = l8; edg = e; start = 1'b1;
    q.push_back('{expd, l8 ? 8 : 16, e, trig});
    @(posedge clk); #1;
    start = 1'b0; tx_data = ~d; len8 = ~l8; edg = ~e;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    tx_data = 16'h6B2D; len8 = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; tx_data = '0; len8 = 1'b0; edg = 1'b0;
    start2 = 1'b0; tx_data2 = '0; len8_2 = 1'b0; edg2 = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("rst_ss_n", 32'(SS_n), 32'(1));
    check("rst_sclk", 32'(SCLK), 32'(1));
    check("rst_mosi", 32'(MOSI), 32'(0));
    check("rst_busy", 32'(busy), 32'(0));
    check("rst_done", 32'(done), 32'(0));
    check("rst_ss_n_div32", 32'(ss2), 32'(1));
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    send(16'h00A5, 1'b1, 1'b0, 16'h00A5, 1'b1);
    send(16'hC3E1, 1'b0, 1'b1, 16'hC3E1, 1'b0);
    send(16'h00A4, 1'b1, 1'b0, 16'h00A4, 1'b0);
    send(16'h00A5, 1'b1, 1'b1, 16'h00A5, 1'b1);
    send(16'hFFFF, 1'b0, 1'b0, 16'hFFFF, 1'b0);
    send(16'h8001, 1'b0, 1'b1, 16'h8001, 1'b0);
    send(16'h1234, 1'b1, 1'b1, 16'h0034, 1'b0);
    send(16'h7F80, 1'b1, 1'b0, 16'h0080, 1'b0);

    // starts during FRONT, SHIFT, GAP and the done cycle are dropped
    send(16'hBEEF, 1'b0, 1'b0, 16'hBEEF, 1'b0);
    pulse_start();
    repeat (10) @(negedge clk);
    pulse_start();
    wait_ss_high0();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done0();
    tx_data = 16'h3C5A; len8 = 1'b0; edg = 1'b1; start = 1'b1;
    q.push_back('{16'h3C5A, 16, 1'b1, 1'b0});
    @(posedge clk); #1;
    @(negedge clk);
    check("b2b_still_idle", 32'(SS_n), 32'(1));
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    check("b2b_front_next", 32'(SS_n), 32'(0));

    // asynchronous abort in SHIFT, then a clean frame
    send(16'hA5A5, 1'b0, 1'b0, 16'hA5A5, 1'b0);
    repeat (12) @(negedge clk);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("abort_ss_n", 32'(SS_n), 32'(1));
    check("abort_sclk", 32'(SCLK), 32'(1));
    check("abort_mosi", 32'(MOSI), 32'(0));
    check("abort_busy", 32'(busy), 32'(0));
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    send(16'h5A5A, 1'b0, 1'b1, 16'h5A5A, 1'b0);
    wait_idle0();

    // back-to-back frames at the default divider
    @(negedge clk);
    tx_data2 = 16'hA55A; start2 = 1'b1;
    @(posedge clk); #1;
    start2 = 1'b0;
    wait_done2();
    @(posedge clk); #1;
    tx_data2 = 16'h0FF0; start2 = 1'b1;
    @(posedge clk); #1;
    start2 = 1'b0;
    wait_done2();
    repeat (4) @(negedge clk);

    check("pending_frames", 32'(q.size()), 32'(0));
    check("idle_levels", 32'(idle_bad0), 32'(0));
    check("idle_levels_div32", 32'(idle_bad2), 32'(0));
    check("frames_div32", 32'(frames2), 32'(2));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #600000;
    fail("watchdog");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1, "watchdog expired");
  end
endmodule
